// File: rtl/aqed_resp_checker.sv
// aqed_resp_checker
// Response-side half of the A-QED harness. Counts accepted inputs and produced
// outputs of an order-preserving core, captures the responses belonging to the
// original and duplicate tokens, and reports the self-consistency result
// (qed_done / qed_check) plus a liveness watchdog on the original (bound_err).
//
// Ports:
//   clk, reset (async, active-low), clk_en (global hold when low)
//   in_v / in_orig / in_dup   : input-side acceptance and token markers
//   out_v / out_data          : core response stream
//   orig_issued, orig_done, dup_done, qed_done, qed_check, orig_val
//   protocol_err (sticky), bound_err (sticky)
module aqed_resp_checker #(
    parameter int unsigned DW      = 16,
    parameter int unsigned CW      = 17,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_en,
    input  logic          in_v,
    input  logic          in_orig,
    input  logic          in_dup,
    input  logic          out_v,
    input  logic [DW-1:0] out_data,
    output logic          orig_issued,
    output logic          orig_done,
    output logic          dup_done,
    output logic          qed_done,
    output logic          qed_check,
    output logic [DW-1:0] orig_val,
    output logic          protocol_err,
    output logic          bound_err
);

    // Watchdog wide enough to reach TIMEOUT and still have headroom to saturate.
    localparam int unsigned WDW = $clog2(TIMEOUT + 2);

    logic [CW-1:0]  in_cnt_q,   in_cnt_d;
    logic [CW-1:0]  out_cnt_q,  out_cnt_d;
    logic [CW-1:0]  orig_idx_q, orig_idx_d;
    logic [CW-1:0]  dup_idx_q,  dup_idx_d;
    logic           orig_issued_q, orig_issued_d;
    logic           dup_armed_q,   dup_armed_d;
    logic           orig_done_q,   orig_done_d;
    logic           dup_done_q,    dup_done_d;
    logic [DW-1:0]  orig_val_q,    orig_val_d;
    logic [DW-1:0]  dup_val_q,     dup_val_d;
    logic           perr_q,        perr_d;
    logic           berr_q,        berr_d;
    logic [WDW-1:0] wd_q,          wd_d;

    logic in_sat;
    logic orig_mark, dup_mark;

    assign in_sat    = (in_cnt_q == '1);
    assign orig_mark = clk_en & in_v & in_orig;
    assign dup_mark  = clk_en & in_v & in_dup;

    always_comb begin
        in_cnt_d      = in_cnt_q;
        out_cnt_d     = out_cnt_q;
        orig_idx_d    = orig_idx_q;
        dup_idx_d     = dup_idx_q;
        orig_issued_d = orig_issued_q;
        dup_armed_d   = dup_armed_q;
        orig_done_d   = orig_done_q;
        dup_done_d    = dup_done_q;
        orig_val_d    = orig_val_q;
        dup_val_d     = dup_val_q;
        perr_d        = perr_q;
        berr_d        = berr_q;
        wd_d          = wd_q;

        if (clk_en) begin
            if (in_v && !in_sat) begin
                in_cnt_d = in_cnt_q + CW'(1);
            end
            if (out_v && (out_cnt_q != '1)) begin
                out_cnt_d = out_cnt_q + CW'(1);
            end

            // Original: only the first one, and only while the index is meaningful.
            if (orig_mark) begin
                if (!orig_issued_q && !in_sat) begin
                    orig_issued_d = 1'b1;
                    orig_idx_d    = in_cnt_q;
                end else begin
                    perr_d = 1'b1;
                end
            end

            // Duplicate: a coincident original always wins, so in_orig blocks arming.
            if (dup_mark) begin
                if (orig_issued_q && !in_orig && !dup_armed_q && !in_sat) begin
                    dup_armed_d = 1'b1;
                    dup_idx_d   = in_cnt_q;
                end else begin
                    perr_d = 1'b1;
                end
            end

            // Registered indices only: a same-cycle issue/response never matches.
            if (out_v && orig_issued_q && !orig_done_q && (out_cnt_q == orig_idx_q)) begin
                orig_done_d = 1'b1;
                orig_val_d  = out_data;
            end
            if (out_v && dup_armed_q && !dup_done_q && (out_cnt_q == dup_idx_q)) begin
                dup_done_d = 1'b1;
                dup_val_d  = out_data;
            end

            if (!orig_issued_q || orig_done_q) begin
                wd_d = '0;
            end else if (wd_q != '1) begin
                wd_d = wd_q + WDW'(1);
            end

            if (orig_issued_q && !orig_done_q && (wd_q == WDW'(TIMEOUT))) begin
                berr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            orig_idx_q    <= '0;
            dup_idx_q     <= '0;
            orig_issued_q <= 1'b0;
            dup_armed_q   <= 1'b0;
            orig_done_q   <= 1'b0;
            dup_done_q    <= 1'b0;
            orig_val_q    <= '0;
            dup_val_q     <= '0;
            perr_q        <= 1'b0;
            berr_q        <= 1'b0;
            wd_q          <= '0;
        end else begin
            in_cnt_q      <= in_cnt_d;
            out_cnt_q     <= out_cnt_d;
            orig_idx_q    <= orig_idx_d;
            dup_idx_q     <= dup_idx_d;
            orig_issued_q <= orig_issued_d;
            dup_armed_q   <= dup_armed_d;
            orig_done_q   <= orig_done_d;
            dup_done_q    <= dup_done_d;
            orig_val_q    <= orig_val_d;
            dup_val_q     <= dup_val_d;
            perr_q        <= perr_d;
            berr_q        <= berr_d;
            wd_q          <= wd_d;
        end
    end

    assign orig_issued  = orig_issued_q;
    assign orig_done    = orig_done_q;
    assign dup_done     = dup_done_q;
    assign qed_done     = orig_done_q & dup_done_q;
    assign qed_check    = orig_done_q & dup_done_q & (orig_val_q == dup_val_q);
    assign orig_val     = orig_val_q;
    assign protocol_err = perr_q;
    assign bound_err    = berr_q;

endmodule

// File: tb/tb_aqed_resp_checker.sv
// Testbench for aqed_resp_checker: directed scenarios plus random traffic,
// checked every cycle against an event-level reference model.
module tb_aqed_resp_checker;

    localparam int unsigned DW      = 16;
    localparam int unsigned CW      = 5;
    localparam int unsigned TIMEOUT = 64;
    localparam int          MAXC    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clk_en = 1'b1;
    logic          in_v = 1'b0, in_orig = 1'b0, in_dup = 1'b0, out_v = 1'b0;
    logic [DW-1:0] out_data = '0;
    logic          orig_issued, orig_done, dup_done, qed_done, qed_check;
    logic [DW-1:0] orig_val;
    logic          protocol_err, bound_err;

    int errors = 0;
    int checks = 0;

    aqed_resp_checker #(.DW(DW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .in_v(in_v), .in_orig(in_orig), .in_dup(in_dup),
        .out_v(out_v), .out_data(out_data),
        .orig_issued(orig_issued), .orig_done(orig_done), .dup_done(dup_done),
        .qed_done(qed_done), .qed_check(qed_check), .orig_val(orig_val),
        .protocol_err(protocol_err), .bound_err(bound_err)
    );

    always #5 clk = ~clk;

    // Reference model: counts in plain integers, watchdog as elapsed enabled cycles.
    int          m_in, m_out, m_ecyc, m_iss_e, m_oidx, m_didx;
    bit          m_issued, m_armed, m_odone, m_ddone, m_perr, m_berr;
    logic [15:0] m_oval, m_dval;

    task automatic model_reset();
        m_in = 0; m_out = 0; m_ecyc = 0; m_iss_e = 0; m_oidx = 0; m_didx = 0;
        m_issued = 0; m_armed = 0; m_odone = 0; m_ddone = 0; m_perr = 0; m_berr = 0;
        m_oval = '0; m_dval = '0;
    endtask

    task automatic model_cycle(input bit v, o, d, ov, input logic [15:0] od, input bit en);
        bit iss0, arm0, sat;
        if (!en) return;
        iss0 = m_issued; arm0 = m_armed; sat = (m_in == MAXC);
        if (iss0 && !m_odone && (m_ecyc - m_iss_e - 1) >= int'(TIMEOUT)) m_berr = 1;
        if (ov && iss0 && !m_odone && m_out == m_oidx) begin m_odone = 1; m_oval = od; end
        if (ov && arm0 && !m_ddone && m_out == m_didx) begin m_ddone = 1; m_dval = od; end
        if (v && o) begin
            if (!iss0 && !sat) begin m_issued = 1; m_oidx = m_in; m_iss_e = m_ecyc; end
            else m_perr = 1;
        end
        if (v && d) begin
            if (iss0 && !o && !arm0 && !sat) begin m_armed = 1; m_didx = m_in; end
            else m_perr = 1;
        end
        if (v && m_in < MAXC) m_in++;
        if (ov && m_out < MAXC) m_out++;
        m_ecyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("orig_issued", 32'(orig_issued), 32'(m_issued));
        chk("orig_done", 32'(orig_done), 32'(m_odone));
        chk("dup_done", 32'(dup_done), 32'(m_ddone));
        chk("qed_done", 32'(qed_done), 32'(m_odone & m_ddone));
        chk("qed_check", 32'(qed_check), 32'(m_odone && m_ddone && m_oval == m_dval));
        chk("orig_val", 32'(orig_val), 32'(m_oval));
        chk("protocol_err", 32'(protocol_err), 32'(m_perr));
        chk("bound_err", 32'(bound_err), 32'(m_berr));
    endtask

    // Drive one cycle, let the edge happen, then compare 1 time unit later.
    task automatic step(input bit v, o, d, ov, input logic [15:0] od, input bit en);
        in_v = v; in_orig = o; in_dup = d; out_v = ov; out_data = od; clk_en = en;
        @(posedge clk);
        model_cycle(v, o, d, ov, od, en);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        in_v = 0; in_orig = 0; in_dup = 0; out_v = 0; clk_en = 1;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Order-preserving echo core: inputs 0..6 on cycles 0..6, response k on cycle k+3.
    task automatic echo(input int oi, input int di, input int ei, input bit bad);
        for (int c = 0; c < 12; c++) begin
            bit          v  = (c <= 6);
            int          r  = c - 3;
            bit          ov = (r >= 0 && r <= 6);
            logic [15:0] dat;
            dat = 16'h1000 | 16'($urandom_range(0, 255));
            if (r == oi || r == di) dat = 16'h00A5;
            if (bad && r == di) dat = 16'h00A4;
            step(v, v && c == oi, v && (c == di || c == ei), ov, dat, 1'b1);
            if (ov && r == oi) chk("orig_done_latency", 32'(orig_done), 32'd1);
        end
    endtask

    initial begin
        int first_b;
        model_reset();
        #3;
        check_all();
        @(posedge clk);
        #1 reset = 1'b1;

        // Matching original and duplicate.
        echo(2, 5, -1, 1'b0);
        chk("s1_qed_done", 32'(qed_done), 32'd1);
        chk("s1_qed_check", 32'(qed_check), 32'd1);
        chk("s1_orig_val", 32'(orig_val), 32'h00A5);
        chk("s1_perr", 32'(protocol_err), 32'd0);

        // Duplicate response differs.
        do_reset();
        echo(2, 5, -1, 1'b1);
        chk("s2_qed_done", 32'(qed_done), 32'd1);
        chk("s2_qed_check", 32'(qed_check), 32'd0);

        // Early duplicate before any original.
        do_reset();
        echo(3, 4, 1, 1'b0);
        chk("s3_perr", 32'(protocol_err), 32'd1);
        chk("s3_qed_done", 32'(qed_done), 32'd1);
        chk("s3_qed_check", 32'(qed_check), 32'd1);

        // Original and duplicate on the same token.
        do_reset();
        echo(0, 0, -1, 1'b0);
        chk("s5_orig_done", 32'(orig_done), 32'd1);
        chk("s5_dup_done", 32'(dup_done), 32'd0);
        chk("s5_perr", 32'(protocol_err), 32'd1);

        // Watchdog: no responses after the original.
        do_reset();
        step(1, 1, 0, 0, '0, 1);
        first_b = -1;
        for (int i = 1; i <= 70; i++) begin
            step(0, 0, 0, 0, '0, 1);
            if (bound_err && first_b < 0) first_b = i;
        end
        chk("bound_latency", 32'(first_b), 32'd65);
        chk("bound_orig_done", 32'(orig_done), 32'd0);

        // clk_en low around a response, then asynchronous reset mid-cycle.
        do_reset();
        step(1, 1, 0, 0, '0, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 1, 1, 16'h1234, 0);
        chk("en_orig_done", 32'(orig_done), 32'd0);
        step(0, 0, 0, 1, 16'h5678, 1);
        chk("en_orig_val", 32'(orig_val), 32'h5678);
        chk("en_orig_done2", 32'(orig_done), 32'd1);
        do_reset();
        chk("rst_orig_val", 32'(orig_val), 32'd0);

        // Input counter saturation blocks markers.
        for (int i = 0; i < MAXC; i++) step(1, 0, 0, 0, '0, 1);
        step(1, 1, 0, 0, '0, 1);
        chk("sat_issued", 32'(orig_issued), 32'd0);
        chk("sat_perr", 32'(protocol_err), 32'd1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 900; i++) begin
            logic [15:0] dat;
            if (i % 300 == 0) do_reset();
            dat = ($urandom_range(0, 1) != 0) ? 16'h00A5 : 16'($urandom);
            step($urandom_range(0, 1) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 14) == 0, $urandom_range(0, 1) != 0, dat,
                 $urandom_range(0, 7) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
